// File: rtl/resp_demux32.sv
// resp_demux32: returns in-order response words from a shared port to one of two
// requesters, using a FIFO of the select tags recorded when requests were issued.
module resp_demux32 #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          req_valid_i,
    input  logic          req_sel_i,
    output logic          req_ready_o,
    input  logic          rsp_valid_i,
    input  logic [31:0]   rsp_data_i,
    output logic          rsp_ready_o,
    output logic [31:0]   data1_o,
    output logic          valid1_o,
    input  logic          ready1_i,
    output logic [31:0]   data2_o,
    output logic          valid2_o,
    input  logic          ready2_i,
    output logic [CW-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] tags;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             out_valid;
    logic             out_sel;
    logic [31:0]      out_data;
    logic             push;
    logic             pop;
    logic             drain;

    // A tag pushed this cycle is not visible to the response side until count updates.
    assign req_ready_o = rst_n_i && (count < CW'(DEPTH));
    assign drain       = out_valid && (out_sel ? ready2_i : ready1_i);
    assign rsp_ready_o = rst_n_i && (count != '0) && (!out_valid || drain);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = rsp_valid_i && rsp_ready_o;

    assign valid1_o = out_valid && !out_sel;
    assign valid2_o = out_valid && out_sel;
    assign data1_o  = out_sel ? 32'd0 : out_data;
    assign data2_o  = out_sel ? out_data : 32'd0;
    assign count_o  = count;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tags      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_sel   <= 1'b0;
            out_data  <= 32'd0;
        end else begin
            if (push) begin
                tags[wr_ptr] <= req_sel_i;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) begin
                out_data  <= rsp_data_i;
                out_sel   <= tags[rd_ptr];
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + PW'(1);
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_resp_demux32.sv
// Scoreboard bench for resp_demux32: stimulus queues expected {port, word} pairs,
// a negedge monitor checks each completed handshake on the requester ports.
module tb_resp_demux32;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i;
    logic        req_sel_i;
    logic        req_ready_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        rsp_ready_o;
    logic [31:0] data1_o;
    logic        valid1_o;
    logic        ready1_i;
    logic [31:0] data2_o;
    logic        valid2_o;
    logic        ready2_i;
    logic [2:0]  count_o;

    int checks   = 0;
    int failures = 0;
    logic [32:0] sb[$];

    resp_demux32 #(.DEPTH(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_sel_i(req_sel_i), .req_ready_o(req_ready_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_ready_o(rsp_ready_o),
        .data1_o(data1_o), .valid1_o(valid1_o), .ready1_i(ready1_i),
        .data2_o(data2_o), .valid2_o(valid2_o), .ready2_i(ready2_i),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic sel);
        req_valid_i = 1'b1;
        req_sel_i   = sel;
        step();
        req_valid_i = 1'b0;
    endtask

    // Present one response word, wait (bounded) until it is accepted, then drop valid.
    task automatic send_rsp(input logic [31:0] data, input logic exp_sel);
        int n = 0;
        sb.push_back({exp_sel, data});
        rsp_valid_i = 1'b1;
        rsp_data_i  = data;
        #1;
        while (!rsp_ready_o && n < 20) begin
            step();
            n++;
        end
        checkOutput("rsp_accept_timeout", 32'(rsp_ready_o), 32'd1);
        step();
        rsp_valid_i = 1'b0;
    endtask

    // Monitor: every completed requester handshake must match the oldest queued word.
    always @(negedge clk_i) begin
        logic [32:0] exp_item;
        checkOutput("one_hot_valid", 32'(valid1_o && valid2_o), 32'd0);
        if (valid1_o && ready1_i) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_port1_word", data1_o, 32'hDEAD_DEAD);
            end else begin
                exp_item = sb.pop_front();
                checkOutput("port1_route", 32'(exp_item[32]), 32'd0);
                checkOutput("port1_data", data1_o, exp_item[31:0]);
                checkOutput("port2_idle_zero", data2_o, 32'd0);
            end
        end
        if (valid2_o && ready2_i) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_port2_word", data2_o, 32'hDEAD_DEAD);
            end else begin
                exp_item = sb.pop_front();
                checkOutput("port2_route", 32'(exp_item[32]), 32'd1);
                checkOutput("port2_data", data2_o, exp_item[31:0]);
                checkOutput("port1_idle_zero", data1_o, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        rst_n_i = 1'b0; req_valid_i = 1'b0; req_sel_i = 1'b0;
        rsp_valid_i = 1'b0; rsp_data_i = 32'd0; ready1_i = 1'b0; ready2_i = 1'b0;
        step();
        step();
        checkOutput("rst_req_ready", 32'(req_ready_o), 32'd0);
        checkOutput("rst_rsp_ready", 32'(rsp_ready_o), 32'd0);
        checkOutput("rst_count", 32'(count_o), 32'd0);
        checkOutput("rst_valids", 32'({valid1_o, valid2_o}), 32'd0);
        checkOutput("rst_data1", data1_o, 32'd0);
        checkOutput("rst_data2", data2_o, 32'd0);
        rst_n_i = 1'b1;
        #1;
        checkOutput("post_rst_req_ready", 32'(req_ready_o), 32'd1);
        checkOutput("post_rst_rsp_ready_empty", 32'(rsp_ready_o), 32'd0);

        // Basic routing
        ready1_i = 1'b1; ready2_i = 1'b1;
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("basic_count2", 32'(count_o), 32'd2);
        send_rsp(32'hAAAA_0001, 1'b0);
        checkOutput("basic_valid1", 32'(valid1_o), 32'd1);
        checkOutput("basic_data1", data1_o, 32'hAAAA_0001);
        checkOutput("basic_data2_idle", data2_o, 32'd0);
        send_rsp(32'hBBBB_0002, 1'b1);
        checkOutput("basic_valid2", 32'(valid2_o), 32'd1);
        checkOutput("basic_data2", data2_o, 32'hBBBB_0002);
        checkOutput("basic_data1_idle", data1_o, 32'd0);
        checkOutput("basic_count0", 32'(count_o), 32'd0);
        step();

        // Full
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("full_count4", 32'(count_o), 32'd4);
        checkOutput("full_req_ready", 32'(req_ready_o), 32'd0);
        applyStimulus(1'b1);
        checkOutput("full_fifth_ignored", 32'(count_o), 32'd4);
        sb.push_back({1'b0, 32'h1111_0000});
        rsp_valid_i = 1'b1; rsp_data_i = 32'h1111_0000;
        req_valid_i = 1'b1; req_sel_i = 1'b0;
        #1;
        checkOutput("full_pop_rsp_ready", 32'(rsp_ready_o), 32'd1);
        checkOutput("full_pop_req_ready", 32'(req_ready_o), 32'd0);
        step();
        rsp_valid_i = 1'b0; req_valid_i = 1'b0;
        checkOutput("full_count3", 32'(count_o), 32'd3);
        send_rsp(32'h2222_0001, 1'b1);
        send_rsp(32'h3333_0002, 1'b0);
        send_rsp(32'h4444_0003, 1'b1);
        step();
        checkOutput("full_drained_count", 32'(count_o), 32'd0);

        // Backpressure on port 2
        ready1_i = 1'b1; ready2_i = 1'b0;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        send_rsp(32'h5555_0001, 1'b1);
        rsp_valid_i = 1'b1; rsp_data_i = 32'h5555_0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_valid2_held", 32'(valid2_o), 32'd1);
            checkOutput("bp_data2_stable", data2_o, 32'h5555_0001);
            checkOutput("bp_rsp_ready_low", 32'(rsp_ready_o), 32'd0);
            step();
        end
        ready2_i = 1'b1;
        #1;
        checkOutput("bp_release_rsp_ready", 32'(rsp_ready_o), 32'd1);
        sb.push_back({1'b1, 32'h5555_0002});
        step();
        rsp_data_i = 32'h5555_0003;
        sb.push_back({1'b0, 32'h5555_0003});
        checkOutput("bp_back_to_back_ready", 32'(rsp_ready_o), 32'd1);
        step();
        rsp_valid_i = 1'b0;
        checkOutput("bp_word3_port1", data1_o, 32'h5555_0003);
        step();
        checkOutput("bp_count0", 32'(count_o), 32'd0);

        // Empty FIFO: no push-to-pop bypass
        rsp_valid_i = 1'b1; rsp_data_i = 32'h6666_0006;
        req_valid_i = 1'b1; req_sel_i = 1'b0;
        #1;
        checkOutput("empty_rsp_ready_low", 32'(rsp_ready_o), 32'd0);
        step();
        req_valid_i = 1'b0;
        checkOutput("empty_rsp_ready_next", 32'(rsp_ready_o), 32'd1);
        sb.push_back({1'b0, 32'h6666_0006});
        step();
        rsp_valid_i = 1'b0;
        checkOutput("empty_valid1", 32'(valid1_o), 32'd1);
        step();

        // Wrap: tag k pushed alongside response k-1
        for (int k = 0; k <= 10; k++) begin
            req_valid_i = (k < 10);
            req_sel_i   = k[0];
            if (k >= 1) begin
                rsp_valid_i = 1'b1;
                rsp_data_i  = 32'(k - 1) * 32'h0101_0101;
                sb.push_back({k[0] ^ 1'b1, 32'(k - 1) * 32'h0101_0101});
                #1;
                checkOutput("wrap_rsp_ready", 32'(rsp_ready_o), 32'd1);
            end
            step();
        end
        req_valid_i = 1'b0; rsp_valid_i = 1'b0;
        step();
        checkOutput("wrap_count0", 32'(count_o), 32'd0);

        // Reset mid-operation
        ready1_i = 1'b0; ready2_i = 1'b0;
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        send_rsp(32'h7777_0007, 1'b0);
        checkOutput("midrst_count3", 32'(count_o), 32'd3);
        checkOutput("midrst_valid1", 32'(valid1_o), 32'd1);
        sb.delete();
        rst_n_i = 1'b0;
        rsp_valid_i = 1'b1; rsp_data_i = 32'h8888_0008;
        #1;
        checkOutput("midrst_rsp_ready", 32'(rsp_ready_o), 32'd0);
        checkOutput("midrst_req_ready", 32'(req_ready_o), 32'd0);
        step();
        checkOutput("midrst_count", 32'(count_o), 32'd0);
        checkOutput("midrst_valids", 32'({valid1_o, valid2_o}), 32'd0);
        checkOutput("midrst_data1", data1_o, 32'd0);
        checkOutput("midrst_data2", data2_o, 32'd0);
        rsp_valid_i = 1'b0;
        rst_n_i = 1'b1;
        ready1_i = 1'b1; ready2_i = 1'b1;
        step();
        step();
        checkOutput("postrst_count", 32'(count_o), 32'd0);
        checkOutput("postrst_valids", 32'({valid1_o, valid2_o}), 32'd0);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
